// File: rtl/parking_core_n.sv
// parking_core_n: parametrised parking-lot controller.
// Tracks SLOTS spaces with per-slot mm:ss parking timers, opens a timed
// door window on every accepted entry/exit and reports the parked duration
// of each accepted exit.
//
// Handshake: entry_req/exit_req are single-cycle request pulses with no
// back-pressure. Each is either accepted or rejected in the cycle it is
// seen. The outcome appears exactly one clock later: spots/door_open
// change, exit_valid pulses for an accepted exit, and err pulses once if
// anything in that cycle was rejected.
module parking_core_n #(
  parameter int SLOTS     = 4,
  parameter int SLOT_W    = 2,
  parameter int DOOR_SECS = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sec_tick,
  input  logic              entry_req,
  input  logic              exit_req,
  input  logic [SLOT_W-1:0] exit_slot,
  output logic [SLOTS-1:0]  spots,
  output logic [SLOT_W:0]   capacity,
  output logic [SLOT_W-1:0] location,
  output logic              is_full,
  output logic              door_open,
  output logic              exit_valid,
  output logic [5:0]        exit_minutes,
  output logic [5:0]        exit_seconds,
  output logic              err,
  output logic              dbg_state
);

  typedef enum logic {IDLE = 1'b0, DOOR = 1'b1} state_e;

  state_e            state_q;
  logic [3:0]        door_cnt_q;
  logic [SLOTS-1:0]  spots_q;
  logic [SLOTS-1:0]  spots_d;
  logic [5:0]        min_q [SLOTS];
  logic [5:0]        sec_q [SLOTS];
  logic              exit_valid_q;
  logic [5:0]        exit_min_q;
  logic [5:0]        exit_sec_q;
  logic              err_q;

  logic [SLOT_W:0]   free_cnt;
  logic [SLOT_W-1:0] free_loc;
  logic              free_found;
  logic              full_w;
  logic              exit_hit;
  logic [5:0]        exit_m;
  logic [5:0]        exit_s;
  logic              exit_ok;
  logic              entry_ok;
  logic              err_d;

  // Free-slot count and lowest-index free slot from the registered bitmap.
  always_comb begin
    free_cnt   = '0;
    free_loc   = '0;
    free_found = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (!spots_q[i]) begin
        free_cnt = free_cnt + (SLOT_W+1)'(1);
        if (!free_found) begin
          free_loc   = SLOT_W'(i);
          free_found = 1'b1;
        end
      end
    end
  end

  assign full_w = (free_cnt == '0);

  // Occupancy and timer of the slot named by exit_slot; out-of-range is empty.
  always_comb begin
    exit_hit = 1'b0;
    exit_m   = '0;
    exit_s   = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (exit_slot == SLOT_W'(i)) begin
        exit_hit = spots_q[i];
        exit_m   = min_q[i];
        exit_s   = sec_q[i];
      end
    end
  end

  // Request arbitration: exit has priority, only IDLE accepts anything.
  always_comb begin
    exit_ok  = (state_q == IDLE) && exit_req && exit_hit;
    entry_ok = (state_q == IDLE) && entry_req && !exit_ok && !full_w;
    err_d    = (exit_req && !exit_ok) || (entry_req && !entry_ok);
    spots_d  = spots_q;
    for (int i = 0; i < SLOTS; i++) begin
      if (entry_ok && (free_loc == SLOT_W'(i))) spots_d[i] = 1'b1;
      if (exit_ok && (exit_slot == SLOT_W'(i))) spots_d[i] = 1'b0;
    end
  end

  // Door FSM: countdown of sec_tick pulses while the door window is open.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      door_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (exit_ok || entry_ok) begin
            state_q    <= DOOR;
            door_cnt_q <= 4'(DOOR_SECS);
          end
        end
        DOOR: begin
          if (sec_tick) begin
            door_cnt_q <= door_cnt_q - 4'd1;
            if (door_cnt_q <= 4'd1) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Occupancy, exit report and error pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spots_q      <= '0;
      exit_valid_q <= 1'b0;
      exit_min_q   <= '0;
      exit_sec_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      spots_q      <= spots_d;
      exit_valid_q <= exit_ok;
      err_q        <= err_d;
      if (exit_ok) begin
        exit_min_q <= exit_m;
        exit_sec_q <= exit_s;
      end
    end
  end

  // Per-slot mm:ss timers: cleared on entry/exit, count while occupied, saturate at 59:59.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SLOTS; i++) begin
        min_q[i] <= '0;
        sec_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        if ((entry_ok && (free_loc == SLOT_W'(i))) ||
            (exit_ok && (exit_slot == SLOT_W'(i)))) begin
          min_q[i] <= '0;
          sec_q[i] <= '0;
        end else if (sec_tick && spots_q[i]) begin
          if (sec_q[i] == 6'd59) begin
            if (min_q[i] != 6'd59) begin
              min_q[i] <= min_q[i] + 6'd1;
              sec_q[i] <= '0;
            end
          end else begin
            sec_q[i] <= sec_q[i] + 6'd1;
          end
        end
      end
    end
  end

  assign spots        = spots_q;
  assign capacity     = free_cnt;
  assign location     = free_loc;
  assign is_full      = full_w;
  assign door_open    = (state_q == DOOR);
  assign exit_valid   = exit_valid_q;
  assign exit_minutes = exit_min_q;
  assign exit_seconds = exit_sec_q;
  assign err          = err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_parking_core_n.sv
// Directed bench for parking_core_n with an exit-duration scoreboard.
module tb_parking_core_n;

  localparam int SLOTS     = 4;
  localparam int SLOT_W    = 2;
  localparam int DOOR_SECS = 3;

  logic              clk;
  logic              reset;
  logic              sec_tick;
  logic              entry_req;
  logic              exit_req;
  logic [SLOT_W-1:0] exit_slot;
  logic [SLOTS-1:0]  spots;
  logic [SLOT_W:0]   capacity;
  logic [SLOT_W-1:0] location;
  logic              is_full;
  logic              door_open;
  logic              exit_valid;
  logic [5:0]        exit_minutes;
  logic [5:0]        exit_seconds;
  logic              err;
  logic              dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [11:0] exp_q[$];
  logic [SLOTS-1:0] occ;
  int occ_ticks [SLOTS];

  parking_core_n #(.SLOTS(SLOTS), .SLOT_W(SLOT_W), .DOOR_SECS(DOOR_SECS)) dut (
    .clk(clk), .reset(reset), .sec_tick(sec_tick),
    .entry_req(entry_req), .exit_req(exit_req), .exit_slot(exit_slot),
    .spots(spots), .capacity(capacity), .location(location),
    .is_full(is_full), .door_open(door_open), .exit_valid(exit_valid),
    .exit_minutes(exit_minutes), .exit_seconds(exit_seconds),
    .err(err), .dbg_state(dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // model helpers
  function automatic logic [11:0] dur(input int t);
    int c;
    c = (t > 3599) ? 3599 : t;
    return {6'(c / 60), 6'(c % 60)};
  endfunction

  function automatic int model_loc();
    for (int i = 0; i < SLOTS; i++) if (!occ[i]) return i;
    return 0;
  endfunction

  task automatic model_enter();
    int l;
    l = model_loc();
    occ[l] = 1'b1;
    occ_ticks[l] = 0;
  endtask

  task automatic model_exit(input int s);
    exp_q.push_back(dur(occ_ticks[s]));
    occ[s] = 1'b0;
  endtask

  // driver tasks: called at posedge+1, return at posedge+1
  task automatic drive(input logic en, input logic ex, input logic [SLOT_W-1:0] sl);
    entry_req = en;
    exit_req  = ex;
    exit_slot = sl;
    @(posedge clk); #1;
    entry_req = 1'b0;
    exit_req  = 1'b0;
    exit_slot = '0;
  endtask

  task automatic tick();
    for (int i = 0; i < SLOTS; i++) if (occ[i]) occ_ticks[i]++;
    sec_tick = 1'b1;
    @(posedge clk); #1;
    sec_tick = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check_all(input string tag, input logic exp_err, input logic exp_door);
    check({tag, ".spots"},    32'(spots),    32'(occ));
    check({tag, ".capacity"}, 32'(capacity), 32'(SLOTS - $countones(occ)));
    check({tag, ".location"}, 32'(location), 32'(model_loc()));
    check({tag, ".is_full"},  32'(is_full),  32'(occ == '1));
    check({tag, ".err"},      32'(err),      32'(exp_err));
    check({tag, ".door"},     32'(door_open), 32'(exp_door));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".spots"},    32'(spots), 0);
    check({tag, ".capacity"}, 32'(capacity), SLOTS);
    check({tag, ".location"}, 32'(location), 0);
    check({tag, ".is_full"},  32'(is_full), 0);
    check({tag, ".door"},     32'(door_open), 0);
    check({tag, ".exit_valid"}, 32'(exit_valid), 0);
    check({tag, ".exit_min"}, 32'(exit_minutes), 0);
    check({tag, ".exit_sec"}, 32'(exit_seconds), 0);
    check({tag, ".err"},      32'(err), 0);
  endtask

  // scoreboard: every exit_valid pulse pops one expected duration
  always @(negedge clk) begin
    if (reset && exit_valid) begin
      tests_run++;
      assert (exp_q.size() > 0) else begin
        tests_failed++;
        $error("FAIL exit_unexpected: observed %0d:%0d expected no exit", exit_minutes, exit_seconds);
      end
      if (exp_q.size() > 0) begin
        logic [11:0] e;
        e = exp_q.pop_front();
        check("exit_dur", 32'({exit_minutes, exit_seconds}), 32'(e));
      end
    end
  end

  initial begin
    reset = 1'b0; sec_tick = 1'b0; entry_req = 1'b0; exit_req = 1'b0; exit_slot = '0;
    occ = '0;
    for (int i = 0; i < SLOTS; i++) occ_ticks[i] = 0;
    repeat (2) @(posedge clk); #1;
    check_reset_vals("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    // fill the lot
    for (int k = 0; k < SLOTS; k++) begin
      model_enter();
      drive(1'b1, 1'b0, '0);
      check_all("entry", 1'b0, 1'b1);
      ticks(DOOR_SECS + 1);
      check("entry_door_closed", 32'(door_open), 0);
    end
    check("full_flag", 32'(is_full), 1);

    // entry on a full lot
    drive(1'b1, 1'b0, '0);
    check_all("full_entry", 1'b1, 1'b0);
    drive(1'b0, 1'b0, '0);
    check("full_err_one_clk", 32'(err), 0);

    // exit slot 0, then entry during door
    model_exit(0);
    drive(1'b0, 1'b1, 2'd0);
    check_all("exit0", 1'b0, 1'b1);
    check("exit0_valid", 32'(exit_valid), 1);
    drive(1'b1, 1'b0, '0);
    check_all("door_entry", 1'b1, 1'b1);
    check("door_entry_no_exit", 32'(exit_valid), 0);
    ticks(DOOR_SECS - 1);
    check("door_still_open", 32'(door_open), 1);
    tick();
    check("door_closed", 32'(door_open), 0);

    // park in slot 0 for 125 s
    model_enter();
    drive(1'b1, 1'b0, '0);
    check_all("reenter0", 1'b0, 1'b1);
    ticks(125);
    model_exit(0);
    drive(1'b0, 1'b1, 2'd0);
    check_all("exit125", 1'b0, 1'b1);
    check("exit125_min", 32'(exit_minutes), 2);
    check("exit125_sec", 32'(exit_seconds), 5);
    ticks(DOOR_SECS - 1);
    check("exit125_door_open", 32'(door_open), 1);
    tick();
    check("exit125_door_closed", 32'(door_open), 0);
    check("exit125_hold_min", 32'(exit_minutes), 2);
    check("exit125_hold_sec", 32'(exit_seconds), 5);

    // empty slot 2, then exit it again
    model_exit(2);
    drive(1'b0, 1'b1, 2'd2);
    check_all("exit2", 1'b0, 1'b1);
    ticks(DOOR_SECS);
    drive(1'b0, 1'b1, 2'd2);
    check_all("exit_empty", 1'b1, 1'b0);
    check("exit_empty_valid", 32'(exit_valid), 0);

    // fresh lot with slots 0,1 occupied
    reset = 1'b0; #2; reset = 1'b1;
    occ = '0;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      model_enter();
      drive(1'b1, 1'b0, '0);
      ticks(DOOR_SECS);
    end
    check_all("two_parked", 1'b0, 1'b0);

    // simultaneous: exit accepted, entry dropped
    model_exit(1);
    drive(1'b1, 1'b1, 2'd1);
    check_all("simul_exit_ok", 1'b1, 1'b1);
    check("simul_exit_valid", 32'(exit_valid), 1);
    check("simul_capacity", 32'(capacity), 3);
    ticks(DOOR_SECS);

    // simultaneous: exit rejected (empty slot 3), entry accepted
    model_enter();
    drive(1'b1, 1'b1, 2'd3);
    check_all("simul_exit_bad", 1'b1, 1'b1);
    check("simul_exit_bad_valid", 32'(exit_valid), 0);
    ticks(DOOR_SECS);

    // long stay saturates at 59:59
    ticks(3700);
    model_exit(0);
    drive(1'b0, 1'b1, 2'd0);
    check("sat_min", 32'(exit_minutes), 59);
    check("sat_sec", 32'(exit_seconds), 59);
    check("sat_door", 32'(door_open), 1);

    // async reset while the door is open
    #5;
    reset = 1'b0;
    #1;
    check_reset_vals("async_reset");
    occ = '0;
    @(posedge clk); #1;
    check("reset_held_door", 32'(door_open), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // hard time limit
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/parking_core_n.md
Name: parking_core_n

Overview:
- Parametrised successor to the fixed 4-slot parking controller.
- Supports SLOTS spaces, per-slot parking-duration timers in mm:ss, and a timed door-open window.
- On every exit it reports the parked duration; this replaces the tied-off time path that currently feeds the display.
- Sits between the debouncers/frequency divider and the full/door LED drivers and the multiplexed display.

Parameters:
- SLOTS, 4, number of parking spaces (2..16).
- SLOT_W, 2, index width; must equal clog2(SLOTS).
- DOOR_SECS, 3, door-open duration in sec_tick pulses (1..15).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous active-low reset.
- sec_tick  input  1  one-clk pulse per second from the frequency divider.
- entry_req  input  1  debounced one-clk pulse: car requests entry.
- exit_req  input  1  debounced one-clk pulse: car requests exit.
- exit_slot  input  SLOT_W  slot being vacated; sampled with exit_req.
- spots  output  SLOTS  occupancy bitmap; bit i=1 means slot i is occupied.
- capacity  output  SLOT_W+1  number of free slots.
- location  output  SLOT_W  lowest-index free slot; 0 when full.
- is_full  output  1  high when capacity==0.
- door_open  output  1  high while the door window is active.
- exit_valid  output  1  one-clk pulse: exit accepted, duration fields valid.
- exit_minutes  output  6  duration of the last accepted exit, minutes 0..59.
- exit_seconds  output  6  duration of the last accepted exit, seconds 0..59.
- err  output  1  one-clk pulse: request rejected.

Behaviour:
- Reset values (async, reset==0):
  - spots=0, capacity=SLOTS, location=0, is_full=0, door_open=0.
  - exit_valid=0, exit_minutes=0, exit_seconds=0, err=0.
  - All slot timers 0:00; FSM in IDLE.
- Reset asserted mid-operation aborts any door window and clears all occupancy and timers immediately.
- FSM states: IDLE, DOOR.
  - IDLE to DOOR on an accepted entry or exit.
  - DOOR to IDLE after DOOR_SECS sec_tick pulses. The cycle that enters DOOR loads a countdown of DOOR_SECS. Each sec_tick in DOOR decrements it. On the tick that reaches 0 the FSM returns to IDLE the next cycle.
  - door_open = (state==DOOR), registered.
- Requests are accepted only in IDLE. Any entry_req or exit_req seen in DOOR is dropped and pulses err.
- Entry, accepted when IDLE and not full:
  - spots[location] set the next cycle.
  - That slot's timer is cleared to 0:00.
- Entry when full: no state change, err pulse the next cycle, door stays closed.
- Exit, accepted when IDLE and spots[exit_slot]==1:
  - Next cycle: spots[exit_slot] cleared, exit_valid=1, exit_minutes/exit_seconds = that slot's timer value at the request cycle.
  - exit_minutes/exit_seconds hold until the next accepted exit.
- Exit of an empty slot, or exit_slot >= SLOTS: err pulse, no state change.
- Simultaneous entry_req and exit_req in IDLE:
  - Exit has priority.
  - If the exit is accepted, the entry is dropped with err.
  - If the exit is rejected, the entry is evaluated normally and err still pulses once for the exit.
  - err is a single one-cycle pulse per cycle regardless of the number of rejections.
- Timers:
  - On each sec_tick, every occupied slot's timer increments seconds.
  - 59 wraps to 0 with minutes+1.
  - Saturates at 59:59 (no wrap).
  - Free slots hold 0:00.
  - A sec_tick coinciding with an entry to a slot leaves that slot at 0:00.
- capacity, location and is_full are derived combinationally from registered spots, so they are consistent in the same cycle spots changes.
- location is a priority encode of the lowest 0 bit.
- Latency: request to spots/exit_valid/err/door_open is 1 clk.

Test Plan:
- Reset, then 4 entries each separated by DOOR_SECS+1 sec_ticks -> spots 0001,0011,0111,1111; capacity 3,2,1,0; is_full=1 after the 4th; location=0.
- Full lot, entry_req -> err=1 for one clk; spots stay 1111; door_open stays 0.
- Entry to slot 0, 125 sec_ticks, exit_req with exit_slot=0 -> exit_valid pulse, exit_minutes=2, exit_seconds=5, spots[0]=0, door_open=1 for 3 ticks.
- entry_req during DOOR -> err pulse, spots unchanged. exit_req on an empty slot 2 -> err, no exit_valid.
- Slots 0,1 occupied, IDLE, entry_req and exit_req (slot 1) in the same clk -> spots=01, exit_valid=1, err=1, capacity=3.
- Slot occupied for 3700 sec_ticks -> exit reports 59:59. Reset pulsed while door_open=1 -> all outputs return to reset values asynchronously.
